// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: handshake bundle for one pipeline stage.
// The upstream side (in_*) and downstream side (out_*) are grouped together
// along with the flush squash line, so a stage and its driver share one port.
//
// Handshake rule (both sides): a beat transfers on a rising clk edge exactly
// when valid and ready are both high in the preceding cycle. A producer that
// raises valid keeps it and its payload stable until the transfer happens
// (or a flush/reset discards the beat); ready may change freely.
interface pipe_stage_reg_if #(
  parameter int WIDTH      = 32,
  parameter int CTRL_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;

  // Driver side: upstream producer plus downstream consumer.
  modport master (
    output in_valid, in_data, in_ctrl, flush, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  // The pipeline stage itself.
  modport slave (
    input  in_valid, in_data, in_ctrl, flush, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline register stage with valid/ready flow control,
// flush squash, control-bit gating on bubbles and a saturating stall counter.
//
// Build option: define PIPE_STAGE_SKID_EN to get a two-entry skid stage
// (EMPTY/BUSY/FULL) with a registered in_ready. Without it the stage is a
// single register (EMPTY/BUSY) whose in_ready is !out_valid | out_ready.
//
// fsm_state exposes the state encoding: 0 = EMPTY, 1 = BUSY, 2 = FULL.
module pipe_stage_reg #(
  parameter int WIDTH      = 32,
  parameter int CTRL_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stage_reg_if.slave  bus,
  output logic [15:0]      stall_count,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state;
  logic                  out_valid_q;
  logic [WIDTH-1:0]      main_data;
  logic [CTRL_WIDTH-1:0] main_ctrl;
  logic                  in_fire;
  logic                  out_fire;

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = out_valid_q & bus.out_ready;

`ifdef PIPE_STAGE_SKID_EN

  logic [WIDTH-1:0]      skid_data;
  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic                  in_ready_q;

  // Skid FSM: main register feeds the output, skid catches the one beat that
  // arrives while in_ready was still high but downstream stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_data   <= '0;
      main_ctrl   <= '0;
      skid_data   <= '0;
      skid_ctrl   <= '0;
    end else if (bus.flush) begin
      // Squash everything held; a same-cycle input beat is dropped too.
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_data   <= bus.in_data;
            main_ctrl   <= bus.in_ctrl;
            state       <= BUSY;
            out_valid_q <= 1'b1;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_data <= bus.in_data;
            main_ctrl <= bus.in_ctrl;
          end else if (in_fire) begin
            skid_data  <= bus.in_data;
            skid_ctrl  <= bus.in_ctrl;
            state      <= FULL;
            in_ready_q <= 1'b0;
          end else if (out_fire) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_data  <= skid_data;
            main_ctrl  <= skid_ctrl;
            state      <= BUSY;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // in_ready comes straight from a flop: no path from out_ready.
  assign bus.in_ready = in_ready_q;

`else

  // Single-register FSM: a new beat may replace the held one in the same
  // cycle it leaves, so throughput is full at the cost of a comb in_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      main_data   <= '0;
      main_ctrl   <= '0;
    end else if (bus.flush) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_data   <= bus.in_data;
            main_ctrl   <= bus.in_ctrl;
            state       <= BUSY;
            out_valid_q <= 1'b1;
          end
        end
        BUSY: begin
          if (in_fire) begin
            main_data <= bus.in_data;
            main_ctrl <= bus.in_ctrl;
          end else if (out_fire) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Room exists if nothing is held or the held beat leaves this cycle.
  assign bus.in_ready = ~out_valid_q | bus.out_ready;

`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_data;
  // A bubble must never enable a downstream unit, so ctrl is gated by valid.
  assign bus.out_ctrl  = out_valid_q ? main_ctrl : '0;
  assign fsm_state     = state;

  // Back-pressure counter: counts stalled cycles, saturates, ignores flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (out_valid_q && !bus.out_ready && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32, meaning: data payload width in bits (operands, immediates, addresses).
REQ-002 Parameter CTRL_WIDTH, default 8, meaning: control payload width in bits (one-hot op enables); bits are forced to zero whenever the output is not valid.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port in_valid  input  1  upstream offers a beat.
REQ-006 Port in_ready  output  1  stage accepts a beat this cycle.
REQ-007 Port in_data  input  WIDTH  upstream data payload.
REQ-008 Port in_ctrl  input  CTRL_WIDTH  upstream control payload.
REQ-009 Port flush  input  1  discard all held beats (branch or exception squash).
REQ-010 Port out_valid  output  1  stage presents a beat.
REQ-011 Port out_ready  input  1  downstream accepts the presented beat.
REQ-012 Port out_data  output  WIDTH  presented data payload.
REQ-013 Port out_ctrl  output  CTRL_WIDTH  presented control payload; all-zero when out_valid=0.
REQ-014 Port stall_count  output  16  saturating count of back-pressure cycles.

Function
REQ-015 Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; a beat moves only on a fire.
REQ-016 Latency: a beat accepted at edge N is presented on out_data/out_ctrl with out_valid=1 after edge N (one cycle), when the stage was empty.
REQ-017 Beat order preserved; no beat duplicated or dropped except by flush.
REQ-018 With skid enabled, state machine has three states: EMPTY (0 beats), BUSY (main register holds 1 beat), FULL (main plus skid register hold 2 beats).
REQ-019 EMPTY: in_fire -> BUSY, main <= input; otherwise stay EMPTY.
REQ-020 BUSY: in_fire & out_fire -> BUSY, main <= input; in_fire & !out_fire -> FULL, skid <= input; !in_fire & out_fire -> EMPTY; neither -> hold.
REQ-021 FULL: out_fire -> BUSY, main <= skid; otherwise hold; no input accepted.
REQ-022 in_ready with skid is registered: in_ready = (state != FULL), with no combinational path from out_ready.
REQ-023 out_valid = (state != EMPTY); out_data/out_ctrl always driven from the main register.
REQ-024 Flush: next state EMPTY, both registers invalidated; an in_fire in the same cycle is discarded; flush takes priority over every transfer.
REQ-025 out_data holds its last value when invalid; out_ctrl is forced to zero when invalid, so a bubble never enables downstream units.
REQ-026 stall_count increments by 1 on each cycle with out_valid=1 and out_ready=0, saturates at 16'hFFFF, and is unaffected by flush.

Reset
REQ-027 On rst=1 at a rising edge: state EMPTY, out_valid=0, out_ctrl=0, out_data=0, skid contents=0, stall_count=0, in_ready=1 (in_ready=1 with or without skid).
REQ-028 Reset mid-operation drops all held beats with no output fire; rst has priority over flush and over all transfers.

Configuration
REQ-029 Macro PIPE_STAGE_SKID_EN defined: the two-entry skid implementation of REQ-018..REQ-022 applies, giving full throughput with registered in_ready.
REQ-030 Macro PIPE_STAGE_SKID_EN undefined: single main register only (states EMPTY/BUSY); in_ready = !out_valid | out_ready (combinational); the FULL state and skid register do not exist; all other requirements are unchanged.

Verification
REQ-031 Stream 0x11,0x22,0x33 with out_ready=1 held -> outputs 0x11,0x22,0x33 on consecutive cycles, each one cycle after input, with one beat per cycle.
REQ-032 Skid enabled: BUSY with 0xAA, out_ready=0, in beat 0xBB -> FULL, in_ready=0 next cycle; out_ready=1 -> 0xAA then 0xBB, in_ready back to 1.
REQ-033 FULL, flush=1 together with in_valid=1 and in_data=0xCC -> next cycle out_valid=0, out_ctrl=0, 0xCC never appears at the output.
REQ-034 out_valid=1 with out_ready=0 held for 70000 cycles -> stall_count=16'hFFFF and stays there; rst=1 -> 0.
REQ-035 rst asserted while BUSY with in_ctrl=8'h04 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, stall_count=0.
REQ-036 Skid disabled: out_valid=1, out_ready=0 -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 in the same cycle.
